inst_fetch_buf: RTL and testbench
=================================

# inst_fetch_buf

Instruction fetch buffer between the PC/instruction-memory fetch stage and the decode stage. It queues fetched {PC, instruction} pairs in a small FIFO so fetch keeps running while decode stalls. It also pre-decodes control-flow instructions (beq, blt, jal) and computes their targets, so the PC logic can redirect early. A flush empties the buffer on redirect.

## Interface
Parameters:
- `DEPTH`, 4 — number of FIFO entries; power of two, ≥ 2.

Ports:
- `clk` input 1 — single clock; all state updates on the rising edge.
- `rst` input 1 — synchronous, active-high reset.
- `flush` input 1 — discard all buffered entries; synchronous.
- `in_valid` input 1 — fetch presents a valid pair.
- `in_ready` output 1 — buffer can accept; high when count < DEPTH.
- `in_pc` input 32 — PC of the fetched instruction.
- `in_inst` input 32 — instruction word from instruction memory.
- `out_valid` output 1 — head entry valid for decode.
- `out_ready` input 1 — decode consumes the head this cycle.
- `out_pc` output 32 — PC of the head entry.
- `out_inst` output 32 — instruction word of the head entry.
- `out_is_branch` output 1 — head is beq or blt.
- `out_is_jal` output 1 — head is jal.
- `out_target` output 32 — branch/jump target of the head; 0 when neither flag is set.
- `count` output $clog2(DEPTH+1) — current occupancy.

## Operation
- Push: `in_valid && in_ready` writes {in_pc, in_inst} at the write pointer.
- Pop: `out_valid && out_ready` advances the read pointer.
- Pointers are log2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- Simultaneous push and pop:
  - Count is unchanged.
  - Allowed when full: in_ready stays low when count==DEPTH, even if a pop occurs that cycle (no combinational ready-through).
  - Allowed when empty only under the bypass configuration.
- Pre-decode is combinational from the head entry, with opcode = inst[6:0]:
  - Branch: opcode 1100011 with funct3 000 (beq) or 100 (blt) → out_is_branch=1. out_target = out_pc + sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}).
  - Jal: opcode 1101111 → out_is_jal=1. out_target = out_pc + sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
  - Target addition is modulo 2^32; overflow wraps silently.
  - Other funct3 values with opcode 1100011 (bne, bge, ...) → out_is_branch=0.
- Flush:
  - Next edge: both pointers and count go to 0.
  - Any push in the same cycle is dropped.
  - out_valid is forced low during the flush cycle, so decode consumes nothing.
- Reset: same effect as flush, and takes priority over it.
- Pre-decode flags and out_target are forced to 0 whenever out_valid=0.

## Timing
- Output values after reset: out_valid=0, in_ready=1, count=0, out_is_branch=0, out_is_jal=0, out_target=0. out_pc and out_inst are undefined (storage is not reset), but the flags ignore them.
- Latency without bypass: a push at edge N appears on out_* after edge N, i.e. usable in cycle N+1.
- Throughput: one push and one pop per cycle sustained.
- in_ready and out_valid are registered-state functions (count-based only), except for the bypass path.
- Full boundary: count==DEPTH → in_ready=0. A pop that cycle makes in_ready=1 in the next cycle.
- Empty boundary: count==0 → out_valid=0 (without bypass).
- Flush and rst win over any push or pop in the same cycle.

## Configuration
- `FETCH_BUF_BYPASS_EN` defined:
  - When count==0 and in_valid=1, out_* present in_pc/in_inst combinationally, out_valid=1, and pre-decode runs on the incoming word.
  - If out_ready=1 that cycle, the pair is consumed without being written (count stays 0): zero-cycle latency.
  - If out_ready=0, it is written normally.
  - Flush still forces out_valid=0.
- Not defined: no combinational in→out path; minimum latency is one cycle.

## Test plan
- Reset, then push 4 pairs (PC 0x0,0x4,0x8,0xC) with out_ready=0 → count=4, in_ready=0. Fifth push is ignored. Drain with out_ready=1 → PCs come out in order 0x0..0xC, then out_valid=0.
- Push at PC 0x100 the word 0xFE000EE3 (beq x0,x0,-4) → out_is_branch=1, out_target=0x0FC. Push blt 0x00404463 at PC 0x20 → out_target=0x28.
- Push jal 0x0080006F at PC 0x40 → out_is_jal=1, out_target=0x48. Push bne 0x00001463 → both flags 0, out_target=0.
- Fill to 3, then assert flush together with in_valid=1 → next cycle count=0, out_valid=0, and the pushed pair never appears.
- Continuous push+pop for 2·DEPTH+3 cycles (pointer wrap) → count stays constant, data order is preserved.
- With FETCH_BUF_BYPASS_EN: empty buffer, in_valid=1, out_ready=1, PC 0x200 → out_valid=1 and out_pc=0x200 in the same cycle, count stays 0. Without the macro → out_valid=1 one cycle later.

Source files
------------

// File: rtl/inst_fetch_buf.sv
// Instruction fetch buffer: FIFO of {pc, inst} pairs with branch/jal pre-decode on the head entry.
// Optional macro FETCH_BUF_BYPASS_EN adds a zero-latency empty-buffer bypass from in_* to out_*.
module inst_fetch_buf #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_pc,
  input  logic [31:0]                in_inst,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_inst,
  output logic                       out_is_branch,
  output logic                       out_is_jal,
  output logic [31:0]                out_target,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [2:0] F3_BEQ    = 3'b000;
  localparam logic [2:0] F3_BLT    = 3'b100;

  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   inst_mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          empty, byp, push, pop;
  logic          is_br, is_jal;
  logic signed [31:0] imm;
  logic [31:0]   target;

  function automatic logic signed [31:0] imm_b(input logic [31:0] inst);
    return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  function automatic logic signed [31:0] imm_j(input logic [31:0] inst);
    return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

  assign empty    = (count == '0);
  assign in_ready = (count != FULL);

`ifdef FETCH_BUF_BYPASS_EN
  assign byp = empty && in_valid;
`else
  assign byp = 1'b0;
`endif

  assign out_valid = (!empty || byp) && !flush;
  assign out_pc    = byp ? in_pc   : pc_mem[rd_ptr];
  assign out_inst  = byp ? in_inst : inst_mem[rd_ptr];

  // A bypassed word taken by decode in the same cycle never enters storage.
  assign pop  = out_valid && out_ready && !byp;
  assign push = in_valid && in_ready && !flush && !(byp && out_ready);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= in_pc;
      inst_mem[wr_ptr] <= in_inst;
    end
  end

  // Pre-decode of the head word; flags and target are masked when nothing is presented.
  always_comb begin
    is_br  = (out_inst[6:0] == OP_BRANCH) &&
             ((out_inst[14:12] == F3_BEQ) || (out_inst[14:12] == F3_BLT));
    is_jal = (out_inst[6:0] == OP_JAL);
    imm    = is_jal ? imm_j(out_inst) : imm_b(out_inst);
    target = out_pc + $unsigned(imm);
  end

  assign out_is_branch = out_valid && is_br;
  assign out_is_jal    = out_valid && is_jal;
  assign out_target    = (out_valid && (is_br || is_jal)) ? target : 32'h0;

endmodule

// File: tb/tb_inst_fetch_buf.sv
// Directed, table-driven bench for inst_fetch_buf (DEPTH=4), with hand-written
// sequences for flush, pointer wrap and the empty-buffer latency/bypass case.
module tb_inst_fetch_buf;

  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH+1);

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] BEQ = 32'hFE00_0EE3;
  localparam logic [31:0] BLT = 32'h0040_4463;
  localparam logic [31:0] JAL = 32'h0080_006F;
  localparam logic [31:0] BNE = 32'h0000_1463;
  localparam logic [31:0] BGE = 32'h0000_5463;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, out_ready;
  logic          in_ready, out_valid, out_is_branch, out_is_jal;
  logic [31:0]   in_pc, in_inst, out_pc, out_inst, out_target;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;

  inst_fetch_buf #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .out_is_branch(out_is_branch), .out_is_jal(out_is_jal), .out_target(out_target),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        ordy;
    logic [2:0]  e_count;
    logic        e_ready;
    logic        e_valid;
    logic [31:0] e_pc;
    logic        e_br;
    logic        e_jal;
    logic [31:0] e_tgt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked 4 units later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [31:0] pc, input logic [31:0] inst,
                       input logic ordy, input logic fl);
    in_valid  = iv;
    in_pc     = pc;
    in_inst   = inst;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic add(input logic iv, input logic [31:0] pc, input logic [31:0] inst,
                     input logic ordy, input logic [2:0] ec, input logic er,
                     input logic ev, input logic [31:0] epc, input logic ebr,
                     input logic ejal, input logic [31:0] etgt);
    vec_t v;
    v.iv = iv; v.pc = pc; v.inst = inst; v.ordy = ordy;
    v.e_count = ec; v.e_ready = er; v.e_valid = ev; v.e_pc = epc;
    v.e_br = ebr; v.e_jal = ejal; v.e_tgt = etgt;
    vecs.push_back(v);
  endtask

  logic [31:0] model_q[$];
  logic        skip_out;

  initial begin
    //  iv  pc          inst ordy cnt rdy vld pc        br jal tgt
    add(1, 32'h0,   NOP, 0, 0, 1, 0, 32'h0,   0, 0, 32'h0);
    add(1, 32'h4,   NOP, 0, 1, 1, 1, 32'h0,   0, 0, 32'h0);
    add(1, 32'h8,   NOP, 0, 2, 1, 1, 32'h0,   0, 0, 32'h0);
    add(1, 32'hC,   NOP, 0, 3, 1, 1, 32'h0,   0, 0, 32'h0);
    add(1, 32'h10,  NOP, 0, 4, 0, 1, 32'h0,   0, 0, 32'h0);
    add(1, 32'h10,  NOP, 1, 4, 0, 1, 32'h0,   0, 0, 32'h0);
    add(0, 32'h0,   NOP, 1, 3, 1, 1, 32'h4,   0, 0, 32'h0);
    add(0, 32'h0,   NOP, 1, 2, 1, 1, 32'h8,   0, 0, 32'h0);
    add(0, 32'h0,   NOP, 1, 1, 1, 1, 32'hC,   0, 0, 32'h0);
    add(0, 32'h0,   NOP, 1, 0, 1, 0, 32'h0,   0, 0, 32'h0);
    add(1, 32'h100, BEQ, 0, 0, 1, 0, 32'h0,   0, 0, 32'h0);
    add(0, 32'h0,   NOP, 1, 1, 1, 1, 32'h100, 1, 0, 32'hFC);
    add(1, 32'h20,  BLT, 0, 0, 1, 0, 32'h0,   0, 0, 32'h0);
    add(1, 32'h40,  JAL, 1, 1, 1, 1, 32'h20,  1, 0, 32'h28);
    add(1, 32'h60,  BNE, 1, 1, 1, 1, 32'h40,  0, 1, 32'h48);
    add(1, 32'h64,  BGE, 1, 1, 1, 1, 32'h60,  0, 0, 32'h0);
    add(0, 32'h0,   NOP, 1, 1, 1, 1, 32'h64,  0, 0, 32'h0);
    add(0, 32'h0,   NOP, 0, 0, 1, 0, 32'h0,   0, 0, 32'h0);

    drive(0, 32'h0, NOP, 0, 0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #4;
    chk("rst_valid",  32'(out_valid),     32'd0);
    chk("rst_ready",  32'(in_ready),      32'd1);
    chk("rst_count",  32'(count),         32'd0);
    chk("rst_br",     32'(out_is_branch), 32'd0);
    chk("rst_jal",    32'(out_is_jal),    32'd0);
    chk("rst_target", out_target,         32'd0);
    tick();

    foreach (vecs[i]) begin
      drive(vecs[i].iv, vecs[i].pc, vecs[i].inst, vecs[i].ordy, 0);
      skip_out = 1'b0;
`ifdef FETCH_BUF_BYPASS_EN
      skip_out = (vecs[i].e_count == 0) && vecs[i].iv;
`endif
      #4;
      chk($sformatf("v%0d_count", i), 32'(count),    32'(vecs[i].e_count));
      chk($sformatf("v%0d_ready", i), 32'(in_ready), 32'(vecs[i].e_ready));
      if (!skip_out) begin
        chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
        if (vecs[i].e_valid)
          chk($sformatf("v%0d_pc", i), out_pc, vecs[i].e_pc);
        chk($sformatf("v%0d_br", i),  32'(out_is_branch), 32'(vecs[i].e_br));
        chk($sformatf("v%0d_jal", i), 32'(out_is_jal),    32'(vecs[i].e_jal));
        chk($sformatf("v%0d_tgt", i), out_target,         vecs[i].e_tgt);
      end
      tick();
    end

    // Flush with a concurrent push: the pushed pair must vanish.
    for (int k = 0; k < 3; k++) begin
      drive(1, 32'h300 + 32'(4*k), NOP, 0, 0);
      tick();
    end
    drive(1, 32'h30C, NOP, 1, 1);
    #4;
    chk("flush_cycle_valid", 32'(out_valid), 32'd0);
    chk("flush_cycle_count", 32'(count),     32'd3);
    tick();
    drive(0, 32'h0, NOP, 0, 0);
    #4;
    chk("flush_count", 32'(count),     32'd0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_ready", 32'(in_ready),  32'd1);
    tick();
    drive(1, 32'h400, NOP, 0, 0);
    tick();
    drive(0, 32'h0, NOP, 1, 0);
    #4;
    chk("post_flush_count", 32'(count), 32'd1);
    chk("post_flush_pc",    out_pc,     32'h400);
    tick();
    drive(0, 32'h0, NOP, 0, 0);
    #4;
    chk("post_flush_empty", 32'(count), 32'd0);
    tick();

    // Sustained push+pop across pointer wrap.
    model_q.delete();
    for (int k = 0; k < 2; k++) begin
      drive(1, 32'h500 + 32'(4*k), NOP, 0, 0);
      model_q.push_back(32'h500 + 32'(4*k));
      tick();
    end
    for (int k = 0; k < 2*DEPTH+3; k++) begin
      drive(1, 32'h508 + 32'(4*k), NOP, 1, 0);
      #4;
      chk($sformatf("wrap%0d_count", k), 32'(count),     32'd2);
      chk($sformatf("wrap%0d_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("wrap%0d_pc", k),    out_pc,         model_q[0]);
      tick();
      void'(model_q.pop_front());
      model_q.push_back(32'h508 + 32'(4*k));
    end
    while (model_q.size() > 0) begin
      drive(0, 32'h0, NOP, 1, 0);
      #4;
      chk("wrap_drain_pc", out_pc, model_q[0]);
      tick();
      void'(model_q.pop_front());
    end
    drive(0, 32'h0, NOP, 0, 0);
    #4;
    chk("wrap_end_count", 32'(count), 32'd0);
    tick();

    // Empty buffer latency: bypass hands the word straight through, otherwise one cycle later.
    drive(1, 32'h200, JAL, 1, 0);
    #4;
`ifdef FETCH_BUF_BYPASS_EN
    chk("byp_valid", 32'(out_valid),  32'd1);
    chk("byp_pc",    out_pc,          32'h200);
    chk("byp_jal",   32'(out_is_jal), 32'd1);
    chk("byp_tgt",   out_target,      32'h208);
    tick();
    drive(0, 32'h0, NOP, 1, 0);
    #4;
    chk("byp_count", 32'(count),     32'd0);
    chk("byp_after", 32'(out_valid), 32'd0);
    tick();
`else
    chk("lat_same_cycle_valid", 32'(out_valid), 32'd0);
    tick();
    drive(0, 32'h0, NOP, 1, 0);
    #4;
    chk("lat_next_valid", 32'(out_valid),  32'd1);
    chk("lat_next_pc",    out_pc,          32'h200);
    chk("lat_next_jal",   32'(out_is_jal), 32'd1);
    chk("lat_next_tgt",   out_target,      32'h208);
    chk("lat_next_count", 32'(count),      32'd1);
    tick();
    drive(0, 32'h0, NOP, 0, 0);
    #4;
    chk("lat_drained", 32'(count), 32'd0);
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
